// File: rtl/embcpu4k_pio_gen.sv
// embcpu4k_pio_gen: Avalon-MM GPIO port with direction control, synchronised
// inputs, atomic set/clear of the output register, edge capture and a maskable
// interrupt. Zero-wait-state slave; readdata and irq are decoded combinationally
// from registered state.
module embcpu4k_pio_gen #(
    parameter int unsigned     WIDTH     = 8,
    parameter logic [WIDTH-1:0] DIR_RESET = '0,
    parameter logic [WIDTH-1:0] OUT_RESET = '0,
    parameter int unsigned     EDGE_TYPE = 0,
    parameter int unsigned     IRQ_TYPE  = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe_port,
    output logic             irq
);

    localparam logic [2:0] ADDR_DATA = 3'd0;
    localparam logic [2:0] ADDR_DIR  = 3'd1;
    localparam logic [2:0] ADDR_MASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE = 3'd3;
    localparam logic [2:0] ADDR_SET  = 3'd4;
    localparam logic [2:0] ADDR_CLR  = 3'd5;

    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] direction;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] in_sync;
    logic [WIDTH-1:0] in_prev;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] edge_clr;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] rd;
    logic             wr_en;
    logic             unused_wd;

    assign wr_en     = chipselect & ~write_n;
    assign wd        = writedata[WIDTH-1:0];
    // Upper write-data bits are architecturally ignored when WIDTH < 32.
    assign unused_wd = ^writedata;

    // Two-flop synchroniser plus a delayed copy for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1   <= '0;
            in_sync <= '0;
            in_prev <= '0;
        end else begin
            sync1   <= in_port;
            in_sync <= sync1;
            in_prev <= in_sync;
        end
    end

    // Per-bit edge detect selected by EDGE_TYPE.
    always_comb begin
        edge_det = '0;
        case (EDGE_TYPE)
            0:       edge_det = in_sync & ~in_prev;
            1:       edge_det = ~in_sync & in_prev;
            default: edge_det = in_sync ^ in_prev;
        endcase
    end

    // Output data register with plain, set and clear write ports.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out <= OUT_RESET;
        end else if (wr_en) begin
            case (address)
                ADDR_DATA: data_out <= wd;
                ADDR_SET:  data_out <= data_out | wd;
                ADDR_CLR:  data_out <= data_out & ~wd;
                default:   data_out <= data_out;
            endcase
        end
    end

    // Direction and interrupt-mask registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            direction <= DIR_RESET;
            irq_mask  <= '0;
        end else if (wr_en) begin
            if (address == ADDR_DIR) begin
                direction <= wd;
            end
            if (address == ADDR_MASK) begin
                irq_mask <= wd;
            end
        end
    end

    // Write-one-to-clear mask for the edge capture register.
    always_comb begin
        edge_clr = '0;
        if (wr_en && (address == ADDR_EDGE)) begin
            edge_clr = wd;
        end
    end

    // Edge capture: a fresh edge beats a simultaneous clear of the same bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_cap <= '0;
        end else begin
            edge_cap <= (edge_cap & ~edge_clr) | edge_det;
        end
    end

    // Read mux; set/clear and reserved addresses read as zero.
    always_comb begin
        rd = '0;
        case (address)
            ADDR_DATA: rd = (direction & data_out) | (~direction & in_sync);
            ADDR_DIR:  rd = direction;
            ADDR_MASK: rd = irq_mask;
            ADDR_EDGE: rd = edge_cap;
            default:   rd = '0;
        endcase
    end

    assign readdata = 32'(rd);
    assign out_port = data_out;
    assign oe_port  = direction;

    // Interrupt: captured edges (edge mode) or live input level (level mode).
    always_comb begin
        irq = 1'b0;
        if (IRQ_TYPE == 1) begin
            irq = |(edge_cap & irq_mask);
        end else begin
            irq = |(in_sync & ~direction & irq_mask);
        end
    end

endmodule

// File: tb/tb_embcpu4k_pio_gen.sv
// Bench for embcpu4k_pio_gen: an edge-interrupt and a level-interrupt instance
// share all inputs; directed table vectors plus hand-written timing sequences.
module tb_embcpu4k_pio_gen;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [31:0] rd_e, rd_l;
    logic [7:0]  out_e, out_l, oe_e, oe_l;
    logic        irq_e, irq_l;

    int checks   = 0;
    int failures = 0;

    embcpu4k_pio_gen #(
        .WIDTH(8), .DIR_RESET(8'h0F), .OUT_RESET(8'hA5), .EDGE_TYPE(0), .IRQ_TYPE(1)
    ) dut_e (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_e),
        .in_port(in_port), .out_port(out_e), .oe_port(oe_e), .irq(irq_e)
    );

    embcpu4k_pio_gen #(
        .WIDTH(8), .DIR_RESET(8'h0F), .OUT_RESET(8'hA5), .EDGE_TYPE(0), .IRQ_TYPE(0)
    ) dut_l (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_l),
        .in_port(in_port), .out_port(out_l), .oe_port(oe_l), .irq(irq_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0]  addr;
        logic        wr;
        logic [31:0] wd;
        logic [7:0]  pin;
        logic [31:0] rd;
        logic [7:0]  out;
        logic [7:0]  oe;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        step();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd_chk(input string name, input logic [2:0] a, input logic [31:0] exp);
        address = a;
        #1;
        chk(name, rd_e, exp);
    endtask

    initial begin
        //            addr  wr    wd             pin    rd            out    oe
        tbl[0]  = '{3'd0, 1'b1, 32'h0000_003C, 8'h00, 32'h0000_000C, 8'h3C, 8'h0F};
        tbl[1]  = '{3'd4, 1'b1, 32'h0000_0081, 8'h00, 32'h0000_0000, 8'hBD, 8'h0F};
        tbl[2]  = '{3'd5, 1'b1, 32'h0000_000C, 8'h00, 32'h0000_0000, 8'hB1, 8'h0F};
        tbl[3]  = '{3'd1, 1'b1, 32'h0000_00F0, 8'h00, 32'h0000_00F0, 8'hB1, 8'hF0};
        tbl[4]  = '{3'd0, 1'b1, 32'h0000_00A0, 8'h00, 32'h0000_00A0, 8'hA0, 8'hF0};
        tbl[5]  = '{3'd0, 1'b0, 32'h0000_0000, 8'h05, 32'h0000_00A0, 8'hA0, 8'hF0};
        tbl[6]  = '{3'd0, 1'b0, 32'h0000_0000, 8'h05, 32'h0000_00A5, 8'hA0, 8'hF0};
        tbl[7]  = '{3'd0, 1'b0, 32'h0000_0000, 8'h05, 32'h0000_00A5, 8'hA0, 8'hF0};
        tbl[8]  = '{3'd3, 1'b0, 32'h0000_0000, 8'h05, 32'h0000_0005, 8'hA0, 8'hF0};
        tbl[9]  = '{3'd3, 1'b1, 32'h0000_00FF, 8'h05, 32'h0000_0000, 8'hA0, 8'hF0};
        tbl[10] = '{3'd1, 1'b1, 32'hFFFF_FF00, 8'h05, 32'h0000_0000, 8'hA0, 8'h00};
        tbl[11] = '{3'd0, 1'b0, 32'h0000_0000, 8'h05, 32'h0000_0005, 8'hA0, 8'h00};
        tbl[12] = '{3'd6, 1'b1, 32'h0000_00FF, 8'h05, 32'h0000_0000, 8'hA0, 8'h00};
        tbl[13] = '{3'd7, 1'b1, 32'h0000_00FF, 8'h05, 32'h0000_0000, 8'hA0, 8'h00};

        reset_n    = 1'b0;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        in_port    = 8'h00;
        repeat (3) step();

        chk("reset_out", 32'(out_e), 32'h0000_00A5);
        chk("reset_oe", 32'(oe_e), 32'h0000_000F);
        chk("reset_irq_e", 32'(irq_e), 32'h0);
        chk("reset_irq_l", 32'(irq_l), 32'h0);
        rd_chk("reset_rd_edge", 3'd3, 32'h0);
        rd_chk("reset_rd_mask", 3'd2, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Register-map vectors
        for (int i = 0; i < 14; i++) begin
            address    = tbl[i].addr;
            writedata  = tbl[i].wd;
            chipselect = tbl[i].wr;
            write_n    = ~tbl[i].wr;
            in_port    = tbl[i].pin;
            step();
            chk($sformatf("vec%0d_rd", i), rd_e, tbl[i].rd);
            chk($sformatf("vec%0d_out", i), 32'(out_e), 32'(tbl[i].out));
            chk($sformatf("vec%0d_oe", i), 32'(oe_e), 32'(tbl[i].oe));
            chk($sformatf("vec%0d_irq_e", i), 32'(irq_e), 32'h0);
            chk($sformatf("vec%0d_irq_l", i), 32'(irq_l), 32'h0);
        end
        chipselect = 1'b0;
        write_n    = 1'b1;

        // Falling edges are not captured in rising mode
        in_port = 8'h00;
        repeat (4) step();
        rd_chk("no_fall_cap", 3'd3, 32'h0);

        // Rising edge on bit 0, edge interrupt timing and clear
        wr(3'd2, 32'h0000_0001);
        rd_chk("mask_rd", 3'd2, 32'h0000_0001);
        in_port = 8'h01;
        step();
        chk("edge_k_irq", 32'(irq_e), 32'h0);
        step();
        chk("edge_k1_irq", 32'(irq_e), 32'h0);
        rd_chk("edge_k1_cap", 3'd3, 32'h0);
        chk("level_k1_irq", 32'(irq_l), 32'h1);
        step();
        chk("edge_k2_irq", 32'(irq_e), 32'h1);
        rd_chk("edge_k2_cap", 3'd3, 32'h0000_0001);
        wr(3'd3, 32'h0000_0001);
        chk("edge_clr_irq", 32'(irq_e), 32'h0);
        rd_chk("edge_clr_cap", 3'd3, 32'h0);
        in_port = 8'h00;
        repeat (4) step();
        rd_chk("edge_fall_cap", 3'd3, 32'h0);
        chk("edge_fall_irq", 32'(irq_e), 32'h0);

        // Clear and new edge on the same bit in the same cycle: set wins
        wr(3'd2, 32'h0000_0004);
        in_port = 8'h04;
        step();
        step();
        wr(3'd3, 32'h0000_0004);
        rd_chk("setwins_cap", 3'd3, 32'h0000_0004);
        chk("setwins_irq", 32'(irq_e), 32'h1);
        step();
        rd_chk("setwins_hold", 3'd3, 32'h0000_0004);
        wr(3'd3, 32'h0000_0004);
        rd_chk("setwins_clr", 3'd3, 32'h0);
        chk("setwins_clr_irq", 32'(irq_e), 32'h0);

        // Level interrupt on an input bit, masked off by turning it into an output
        wr(3'd2, 32'h0000_0002);
        chk("level_idle_irq", 32'(irq_l), 32'h0);
        in_port = 8'h06;
        step();
        chk("level_k_irq", 32'(irq_l), 32'h0);
        step();
        chk("level_k1b_irq", 32'(irq_l), 32'h1);
        wr(3'd1, 32'h0000_0002);
        chk("level_dir_oe", 32'(oe_l), 32'h0000_0002);
        chk("level_dir_irq", 32'(irq_l), 32'h0);

        // Asynchronous reset between clock edges
        in_port = 8'h10;
        #2;
        reset_n = 1'b0;
        #1;
        chk("areset_out", 32'(out_e), 32'h0000_00A5);
        chk("areset_oe", 32'(oe_e), 32'h0000_000F);
        chk("areset_out_l", 32'(out_l), 32'h0000_00A5);
        chk("areset_irq_e", 32'(irq_e), 32'h0);
        chk("areset_irq_l", 32'(irq_l), 32'h0);
        rd_chk("areset_mask", 3'd2, 32'h0);
        rd_chk("areset_edge", 3'd3, 32'h0);
        rd_chk("areset_data", 3'd0, 32'h0000_0005);

        // Input held high through reset is captured as a rising edge afterwards
        @(negedge clk);
        reset_n = 1'b1;
        step();
        step();
        rd_chk("post_reset_k1", 3'd3, 32'h0);
        step();
        rd_chk("post_reset_k2", 3'd3, 32'h0000_0010);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
